// File: rtl/osd_dem_uart_pkg.sv
// osd_dem_uart_pkg: DII flit layout, FSM state types and flit builders shared by the
// DEM-UART host endpoint.
package osd_dem_uart_pkg;

   localparam logic [1:0] TYPE_EVENT        = 2'b10;
   localparam logic [3:0] TYPE_SUB_CHAR_DEF = 4'h0;
   localparam int         HDR_TS_LSB        = 10;

   typedef enum logic [2:0] {RX_IDLE, RX_SRC, RX_TYPE, RX_PAYLOAD, RX_DROP} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_F0, TX_F1, TX_F2, TX_F3} tx_state_t;

   typedef struct packed {
      logic [1:0] typ;
      logic [3:0] sub;
      logic [9:0] rsvd;
   } hdr_t;

   function automatic logic [15:0] addr_flit(input logic [9:0] a);
      return {6'b0, a};
   endfunction

   function automatic logic [15:0] hdr_flit(input logic [3:0] sub);
      hdr_t h;
      h.typ  = TYPE_EVENT;
      h.sub  = sub;
      h.rsvd = '0;
      return h;
   endfunction

endpackage

// File: rtl/osd_dem_uart_host_rx.sv
// osd_dem_uart_host_rx: parses incoming DII EVENT packets into a single-entry
// character register and counts every packet it has to discard.
module osd_dem_uart_host_rx
   import osd_dem_uart_pkg::*;
#(
   parameter int         DROP_CNT_W    = 16,
   parameter logic [3:0] TYPE_SUB_CHAR = TYPE_SUB_CHAR_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [9:0]            i_id,
   input  logic [15:0]           i_data,
   input  logic                  i_last,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [7:0]            o_char,
   output logic                  o_valid,
   input  logic                  i_rx_ready,
   output logic [DROP_CNT_W-1:0] o_drop_cnt
);

   rx_state_t             r_state;
   logic                  r_live;
   logic                  r_valid;
   logic [7:0]            r_char;
   logic [DROP_CNT_W-1:0] r_drop;
   logic                  w_acc;
   logic                  w_dest_ok;
   logic                  w_hdr_ok;
   logic                  w_drop;

   // r_live holds ready low until the first cycle after reset release
   assign o_ready   = r_live & ((r_state != RX_PAYLOAD) | !r_valid | i_rx_ready);
   assign w_acc     = i_valid & o_ready;
   assign w_dest_ok = i_data[9:0] == i_id;
   assign w_hdr_ok  = i_data[15:HDR_TS_LSB] == {TYPE_EVENT, TYPE_SUB_CHAR};

   always_comb begin
      w_drop = 1'b0;
      if (w_acc)
         w_drop = (r_state == RX_IDLE)    ? (i_last | !w_dest_ok) :
                  (r_state == RX_SRC)     ? i_last :
                  (r_state == RX_TYPE)    ? (i_last | !w_hdr_ok) :
                  (r_state == RX_PAYLOAD) ? !i_last : 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RX_IDLE;
         r_live  <= 1'b0;
         r_valid <= 1'b0;
         r_char  <= '0;
         r_drop  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_acc) begin
            case (r_state)
               RX_IDLE:    r_state <= i_last ? RX_IDLE : (w_dest_ok ? RX_SRC : RX_DROP);
               RX_SRC:     r_state <= i_last ? RX_IDLE : RX_TYPE;
               RX_TYPE:    r_state <= i_last ? RX_IDLE : (w_hdr_ok ? RX_PAYLOAD : RX_DROP);
               RX_PAYLOAD: r_state <= i_last ? RX_IDLE : RX_DROP;
               default:    r_state <= i_last ? RX_IDLE : RX_DROP;
            endcase
         end
         if (w_acc && r_state == RX_PAYLOAD && i_last) begin
            r_char  <= i_data[7:0];
            r_valid <= 1'b1;
         end else if (i_rx_ready) begin
            r_valid <= 1'b0;
         end
         if (w_drop && !(&r_drop))
            r_drop <= r_drop + 1'b1;
      end
   end

   assign o_char     = r_char;
   assign o_valid    = r_valid;
   assign o_drop_cnt = r_drop;

endmodule

// File: rtl/osd_dem_uart_host.sv
// osd_dem_uart_host: byte-stream host view of a DEM-UART; RX parser in a sub-module,
// TX packetiser inline.
module osd_dem_uart_host
   import osd_dem_uart_pkg::*;
#(
   parameter int         DROP_CNT_W    = 16,
   parameter logic [3:0] TYPE_SUB_CHAR = TYPE_SUB_CHAR_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [9:0]            i_id,
   input  logic [9:0]            i_dem_id,
   input  logic [15:0]           i_dii_in_data,
   input  logic                  i_dii_in_last,
   input  logic                  i_dii_in_valid,
   output logic                  o_dii_in_ready,
   output logic [15:0]           o_dii_out_data,
   output logic                  o_dii_out_last,
   output logic                  o_dii_out_valid,
   input  logic                  i_dii_out_ready,
   output logic [7:0]            o_rx_char,
   output logic                  o_rx_valid,
   input  logic                  i_rx_ready,
   input  logic [7:0]            i_tx_char,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic [DROP_CNT_W-1:0] o_drop_cnt
);

   tx_state_t   r_tx_state;
   logic [7:0]  r_tx_char;
   logic        r_tx_ready;
   logic [15:0] r_out_data;
   logic        r_out_last;
   logic        r_out_valid;

   osd_dem_uart_host_rx #(
      .DROP_CNT_W    (DROP_CNT_W),
      .TYPE_SUB_CHAR (TYPE_SUB_CHAR)
   ) u_rx (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_id       (i_id),
      .i_data     (i_dii_in_data),
      .i_last     (i_dii_in_last),
      .i_valid    (i_dii_in_valid),
      .o_ready    (o_dii_in_ready),
      .o_char     (o_rx_char),
      .o_valid    (o_rx_valid),
      .i_rx_ready (i_rx_ready),
      .o_drop_cnt (o_drop_cnt)
   );

   // each state's flit is loaded on entry so the outputs stay registered and stable
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_state  <= TX_IDLE;
         r_tx_char   <= '0;
         r_tx_ready  <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_tx_state)
            TX_IDLE:
               if (i_tx_valid && r_tx_ready) begin
                  r_tx_char   <= i_tx_char;
                  r_out_data  <= addr_flit(i_dem_id);
                  r_out_valid <= 1'b1;
                  r_tx_ready  <= 1'b0;
                  r_tx_state  <= TX_F0;
               end else begin
                  r_tx_ready <= 1'b1;
               end
            TX_F0:
               if (i_dii_out_ready) begin
                  r_out_data <= addr_flit(i_id);
                  r_tx_state <= TX_F1;
               end
            TX_F1:
               if (i_dii_out_ready) begin
                  r_out_data <= hdr_flit(TYPE_SUB_CHAR);
                  r_tx_state <= TX_F2;
               end
            TX_F2:
               if (i_dii_out_ready) begin
                  r_out_data <= {8'h00, r_tx_char};
                  r_out_last <= 1'b1;
                  r_tx_state <= TX_F3;
               end
            TX_F3:
               if (i_dii_out_ready) begin
                  r_out_data  <= '0;
                  r_out_last  <= 1'b0;
                  r_out_valid <= 1'b0;
                  r_tx_ready  <= 1'b1;
                  r_tx_state  <= TX_IDLE;
               end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   assign o_dii_out_data  = r_out_data;
   assign o_dii_out_last  = r_out_last;
   assign o_dii_out_valid = r_out_valid;
   assign o_tx_ready      = r_tx_ready;

endmodule

// File: tb/tb_osd_dem_uart_host.sv
// tb_osd_dem_uart_host: directed and randomized traffic against a packet-level model
// of the DEM-UART host endpoint.
module tb_osd_dem_uart_host;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  id = 10'h005;
   logic [9:0]  dem_id = 10'h003;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  rx_char;
   logic        rx_valid;
   logic        rx_ready = 1'b1;
   logic [7:0]  tx_char = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [15:0] drop_cnt;
   logic        in_ready2, out_last2, out_valid2, rx_valid2, tx_ready2;
   logic [15:0] out_data2;
   logic [7:0]  rx_char2;
   logic [1:0]  drop2;

   int checks = 0;
   int errors = 0;
   int exp_drops = 0;
   int out_mode = 0;
   bit rx_rand = 0;
   logic [7:0]  q_rx_got[$], q_rx_exp[$];
   logic [16:0] q_tx_got[$], q_tx_exp[$];
   logic        stalled = 1'b0;
   logic [16:0] held = '0;

   always #5 clk = ~clk;

   osd_dem_uart_host dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_id(id), .i_dem_id(dem_id),
      .i_dii_in_data(in_data), .i_dii_in_last(in_last), .i_dii_in_valid(in_valid),
      .o_dii_in_ready(in_ready), .o_dii_out_data(out_data), .o_dii_out_last(out_last),
      .o_dii_out_valid(out_valid), .i_dii_out_ready(out_ready), .o_rx_char(rx_char),
      .o_rx_valid(rx_valid), .i_rx_ready(rx_ready), .i_tx_char(tx_char),
      .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .o_drop_cnt(drop_cnt)
   );

   // narrow counter twin: sees identical traffic and must pin at 2'b11
   osd_dem_uart_host #(.DROP_CNT_W(2)) dut_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_id(id), .i_dem_id(dem_id),
      .i_dii_in_data(in_data), .i_dii_in_last(in_last), .i_dii_in_valid(in_valid),
      .o_dii_in_ready(in_ready2), .o_dii_out_data(out_data2), .o_dii_out_last(out_last2),
      .o_dii_out_valid(out_valid2), .i_dii_out_ready(out_ready), .o_rx_char(rx_char2),
      .o_rx_valid(rx_valid2), .i_rx_ready(rx_ready), .i_tx_char(tx_char),
      .i_tx_valid(tx_valid), .o_tx_ready(tx_ready2), .o_drop_cnt(drop2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0][15:0] pk(input logic [15:0] a, b, c, d, e);
      return {e, d, c, b, a};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid && rx_ready) q_rx_got.push_back(rx_char);
         if (out_valid && out_ready) q_tx_got.push_back({out_last, out_data});
         if (stalled) chk("tx_hold", {15'b0, out_valid, out_last, out_data}, {15'b0, 1'b1, held});
         if (out_valid) chk("tx_ready_busy", {31'b0, tx_ready}, 0);
         stalled = out_valid && !out_ready;
         held = {out_last, out_data};
      end else begin
         stalled = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rx_rand) rx_ready = 1'($urandom_range(0, 1));
      if (out_mode == 1) out_ready = ~out_ready;
      if (out_mode == 2) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic rx_send(input int n, input logic [4:0][15:0] f);
      for (int k = 0; k < n; k++) begin
         bit acc = 0;
         int t = 0;
         in_valid = 1'b1;
         in_data = f[k];
         in_last = (k == n - 1);
         while (!acc && t < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
         end
         chk("rx_flit_accepted", {31'b0, acc}, 1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
   endtask

   // packet-level model: deliverable only as exactly four flits to our id with a char EVENT header
   task automatic rx_pkt(input int n, input logic [4:0][15:0] f);
      if (n == 4 && f[0][9:0] == id && f[2][15:14] == 2'b10 && f[2][13:10] == 4'h0)
         q_rx_exp.push_back(f[3][7:0]);
      else
         exp_drops++;
      rx_send(n, f);
   endtask

   task automatic tx_send(input logic [7:0] c);
      bit acc = 0;
      int t = 0;
      q_tx_exp.push_back({1'b0, 6'b0, dem_id});
      q_tx_exp.push_back({1'b0, 6'b0, id});
      q_tx_exp.push_back({1'b0, 16'h8000});
      q_tx_exp.push_back({1'b1, 8'h00, c});
      tx_valid = 1'b1;
      tx_char = c;
      while (!acc && t < 300) begin
         @(negedge clk);
         acc = tx_ready;
         @(posedge clk);
         #1;
         t++;
      end
      chk("tx_char_accepted", {31'b0, acc}, 1);
      tx_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t = 0;
      rx_rand = 0;
      rx_ready = 1'b1;
      out_mode = 0;
      out_ready = 1'b1;
      while ((q_rx_got.size() < q_rx_exp.size() || q_tx_got.size() < q_tx_exp.size()) && t < 500) begin
         @(posedge clk);
         t++;
      end
      repeat (8) @(posedge clk);
      #1;
      chk({tag, "_rx_count"}, q_rx_got.size(), q_rx_exp.size());
      chk({tag, "_tx_count"}, q_tx_got.size(), q_tx_exp.size());
      for (int i = 0; i < q_rx_got.size() && i < q_rx_exp.size(); i++)
         chk({tag, "_rx_char"}, {24'b0, q_rx_got[i]}, {24'b0, q_rx_exp[i]});
      for (int i = 0; i < q_tx_got.size() && i < q_tx_exp.size(); i++)
         chk({tag, "_tx_flit"}, {15'b0, q_tx_got[i]}, {15'b0, q_tx_exp[i]});
      chk({tag, "_drop_cnt"}, {16'b0, drop_cnt}, exp_drops);
      chk({tag, "_drop_sat"}, {30'b0, drop2}, exp_drops > 3 ? 3 : exp_drops);
      q_rx_got.delete();
      q_rx_exp.delete();
      q_tx_got.delete();
      q_tx_exp.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 0);
      chk({tag, "_rx_valid"}, {31'b0, rx_valid}, 0);
      chk({tag, "_rx_char"}, {24'b0, rx_char}, 0);
      chk({tag, "_out"}, {14'b0, out_valid, out_last, out_data}, 0);
      chk({tag, "_tx_ready"}, {31'b0, tx_ready}, 0);
      chk({tag, "_drop_cnt"}, {16'b0, drop_cnt}, 0);
      chk({tag, "_drop_sat"}, {30'b0, drop2}, 0);
   endtask

   initial begin
      logic [4:0][15:0] rf;
      int rn;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_in_ready", {31'b0, in_ready}, 1);
      chk("idle_tx_ready", {31'b0, tx_ready}, 1);

      rx_pkt(4, pk(16'h0005, 16'h0002, 16'h8000, 16'h0041, 16'h0));
      chk("rx_latency_valid", {31'b0, rx_valid}, 1);
      chk("rx_latency_char", {24'b0, rx_char}, 8'h41);
      @(posedge clk);
      #1;
      chk("rx_valid_one_cycle", {31'b0, rx_valid}, 0);
      drain("wellformed");

      rx_ready = 1'b0;
      fork
         begin
            rx_pkt(4, pk(16'h0005, 16'h0002, 16'h8000, 16'h0041, 16'h0));
            rx_pkt(4, pk(16'h0005, 16'h0002, 16'h8000, 16'h0042, 16'h0));
         end
         begin
            repeat (30) @(posedge clk);
            #1;
            chk("bp_in_ready_low", {31'b0, in_ready}, 0);
            chk("bp_held_valid", {31'b0, rx_valid}, 1);
            chk("bp_held_char", {24'b0, rx_char}, 8'h41);
            rx_ready = 1'b1;
         end
      join
      drain("backpressure");

      rx_pkt(4, pk(16'h0006, 16'h0002, 16'h8000, 16'h0041, 16'h0));
      #1;
      chk("drop_after_one", {16'b0, drop_cnt}, 1);
      rx_pkt(4, pk(16'h0005, 16'h0002, 16'h0000, 16'h0041, 16'h0));
      rx_pkt(5, pk(16'h0005, 16'h0002, 16'h8000, 16'h0041, 16'h0042));
      drain("drops");

      out_mode = 1;
      tx_send(8'h5A);
      repeat (20) @(posedge clk);
      drain("transmit");

      fork
         rx_pkt(4, pk(16'h0005, 16'h0002, 16'h8000, 16'h0078, 16'h0));
         tx_send(8'h79);
      join
      drain("concurrent");

      rx_rand = 1;
      out_mode = 2;
      repeat (30) begin
         rn = $urandom_range(1, 5);
         rf[0] = ($urandom_range(0, 3) != 0) ? {6'($urandom), id} : 16'($urandom);
         rf[1] = 16'($urandom);
         rf[2] = ($urandom_range(0, 3) != 0) ? (16'h8000 | 16'($urandom_range(0, 1023))) : 16'($urandom);
         rf[3] = 16'($urandom);
         rf[4] = 16'($urandom);
         fork
            rx_pkt(rn, rf);
            tx_send(8'($urandom));
         join
      end
      drain("random");

      out_mode = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h0005;
      tx_valid = 1'b1;
      tx_char = 8'h33;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      in_data = 16'h0002;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_data = 16'h8000;
      chk("pre_reset_f1", {15'b0, out_valid, out_data}, {15'b0, 1'b1, 6'b0, id});
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      in_valid = 1'b0;
      in_data = '0;
      exp_drops = 0;
      q_tx_got.delete();
      q_rx_got.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      fork
         rx_pkt(4, pk(16'h0005, 16'h0002, 16'h8000, 16'h0052, 16'h0));
         tx_send(8'h54);
      join
      drain("after_reset");

      for (int i = 0; i < 5; i++)
         rx_pkt(1, pk(16'h0005, 16'h0, 16'h0, 16'h0, 16'h0));
      drain("saturate");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/osd_dem_uart_host.md
Name: osd_dem_uart_host

Overview:
Peer endpoint of the DEM-UART event protocol on the debug interconnect (DII). It receives DII EVENT packets carrying a character and presents the character on a byte stream. In the other direction, it packs host-supplied characters into DII EVENT packets addressed to the DEM-UART module. It sits beside the debug-host bridge (or a simulation host model) and gives the host a plain byte-stream UART view.

Parameters:
- DROP_CNT_W, 16, width of the saturating dropped-packet counter.
- TYPE_SUB_CHAR, 4'h0, EVENT subtype used for character packets (TX and RX check).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- id  in  10  own DII address
- dem_id  in  10  DII address of the target DEM-UART; sampled at packet start
- dii_in_data  in  16  incoming flit
- dii_in_last  in  1  last flit of packet
- dii_in_valid  in  1  flit valid
- dii_in_ready  out  1  flit accepted
- dii_out_data  out  16  outgoing flit
- dii_out_last  out  1  last flit
- dii_out_valid  out  1  flit valid
- dii_out_ready  in  1  downstream ready
- rx_char  out  8  character from the DEM-UART
- rx_valid  out  1  rx_char valid
- rx_ready  in  1  host consumes rx_char
- tx_char  in  8  character to the DEM-UART
- tx_valid  in  1  tx_char valid
- tx_ready  out  1  tx_char accepted
- drop_cnt  out  DROP_CNT_W  count of dropped packets, saturating

Behaviour:
- Packet format (shared package), one flit per cycle, transfer when valid&ready:
  - F0 = {6'b0, dest[9:0]}
  - F1 = {6'b0, src[9:0]}
  - F2 = {type[1:0]=2'b10 EVENT, subtype[3:0], 10'b0}
  - F3 = {8'h00, char}, with last=1
- Reset (rst low, asynchronous) clears the following, and both FSMs go to IDLE:
  - rx_valid, rx_char=0
  - dii_in_ready=0
  - dii_out_valid, dii_out_last, dii_out_data=0
  - tx_ready=0
  - drop_cnt=0
- Reset mid-packet abandons the packet. There is no resynchronisation beyond the next last flag.
- RX FSM states:
  - IDLE: expects F0, dii_in_ready=1.
    - On accept: if dest==id go to SRC; else go to DROP.
    - If F0 also has last=1, count a drop and stay in IDLE.
  - SRC: accept any F1.
    - last=1 -> drop, go to IDLE.
    - Otherwise go to TYPE.
  - TYPE: go to PAYLOAD if type==EVENT and subtype==TYPE_SUB_CHAR and last=0; else drop.
    - If last=1 -> IDLE; else -> DROP.
  - PAYLOAD: dii_in_ready = !rx_valid | rx_ready (single output register, no bubble).
    - On accept with last=1: rx_char<=data[7:0], rx_valid<=1, go to IDLE.
    - With last=0: character discarded, drop counted, go to DROP.
  - DROP: dii_in_ready=1, swallow flits until last, then go to IDLE.
  - Each dropped packet increments drop_cnt once. drop_cnt saturates at all-ones.
- rx_valid clears on rx_ready unless a new character loads in the same cycle. Simultaneous load and consume keeps rx_valid=1 with the new character.
- RX latency: rx_valid rises the cycle after F3 is accepted.
- TX FSM states:
  - IDLE: tx_ready=1. On tx_valid, latch tx_char and dem_id, go to F0.
  - F0, F1, F2, F3: present the flit with dii_out_valid=1. Advance only when dii_out_ready=1.
    - Data, valid and last are registered and held stable while stalled.
    - F3 asserts last. After F3 is accepted, go to IDLE.
  - F1 src = id.
  - tx_ready is 0 in every state except IDLE. Throughput is one character per 5 cycles at full ready.
- RX and TX are fully independent. Simultaneous traffic in both directions is legal.

Decomposition:
- Package osd_dem_uart_pkg holds:
  - flit layout constants: type field position, EVENT=2'b10, TYPE_SUB_CHAR default
  - typedefs: rx_state_t {IDLE, SRC, TYPE, PAYLOAD, DROP} and tx_state_t {IDLE, F0, F1, F2, F3}
  - a packed struct for the F2 header
- The RX path is a natural sub-module, osd_dem_uart_host_rx (parser, output register, drop counter). TX stays inline.

Test Plan:
- Well-formed receive: id=10'h005, packet {0x0005, 0x0002, 0x8000, 0x0041 last} with rx_ready=1 -> rx_char=0x41, rx_valid=1 for one cycle, drop_cnt=0.
- Backpressure: rx_ready=0, send two char packets 'A' then 'B' -> first held. Second F3 stalls with dii_in_ready=0 until rx_ready=1; output is 'A' then 'B', no loss.
- Drop cases, drop_cnt goes 0->3 with no rx_valid:
  - wrong dest 0x0006
  - type 2'b00 header 0x0000
  - 5-flit packet with extra flit after F3
- Transmit: dem_id=10'h003, id=10'h005, tx_char=0x5A -> flits 0x0003, 0x0005, 0x8000, 0x005A(last). With dii_out_ready toggling 1/0, each flit is held stable and tx_ready is low until F3 is accepted.
- Concurrency: receive 'x' while transmitting 'y' in the same cycles -> both complete correctly.
- Reset: assert rst low mid-RX at TYPE and mid-TX at F1 -> all outputs 0 immediately. After release, a fresh packet is received and sent correctly.
- Saturation: force drop_cnt to 16'hFFFE, send 3 bad packets -> drop_cnt=16'hFFFF.
